decode_stage: RTL and testbench

//  LC-3b pipeline DE stage, directly downstream of fetch. Owns the DE latches (NPC/IR/V), the 8x16 register

---
 rtl/lc3b_pkg.sv | 38 +++
 rtl/decode_stage_if.sv | 55 +++++
 rtl/lc3b_regfile.sv | 42 ++++
 rtl/decode_stage.sv | 188 ++++++++++++++++++
 tb/tb_decode_stage.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/lc3b_pkg.sv
// Shared LC-3b decode constants: opcodes, AGEX control-word bit positions, register constants.
package lc3b_pkg;

    localparam int unsigned XLEN    = 16;
    localparam int unsigned REG_AW  = 3;
    localparam int unsigned NREGS   = 8;
    localparam int unsigned CC_W    = 3;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned CS_BITS = 8;

    localparam logic [OP_W-1:0] OP_BR   = 4'h0;
    localparam logic [OP_W-1:0] OP_ADD  = 4'h1;
    localparam logic [OP_W-1:0] OP_LDB  = 4'h2;
    localparam logic [OP_W-1:0] OP_STB  = 4'h3;
    localparam logic [OP_W-1:0] OP_JSR  = 4'h4;
    localparam logic [OP_W-1:0] OP_AND  = 4'h5;
    localparam logic [OP_W-1:0] OP_LDW  = 4'h6;
    localparam logic [OP_W-1:0] OP_STW  = 4'h7;
    localparam logic [OP_W-1:0] OP_RTI  = 4'h8;
    localparam logic [OP_W-1:0] OP_XOR  = 4'h9;
    localparam logic [OP_W-1:0] OP_JMP  = 4'hC;
    localparam logic [OP_W-1:0] OP_SHF  = 4'hD;
    localparam logic [OP_W-1:0] OP_LEA  = 4'hE;
    localparam logic [OP_W-1:0] OP_TRAP = 4'hF;

    // Bit positions inside the AGEX control word
    localparam int unsigned CS_LD_REG = 0;
    localparam int unsigned CS_LD_CC  = 1;
    localparam int unsigned CS_BR_OP  = 2;
    localparam int unsigned CS_MEM_EN = 3;
    localparam int unsigned CS_MEM_WE = 4;
    localparam int unsigned CS_WORD   = 5;
    localparam int unsigned CS_SR2MUX = 6;
    localparam int unsigned CS_JSR    = 7;

    localparam logic [REG_AW-1:0] R7 = 3'd7;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch / DE / AGEX / MEM / SR signal bundle around the decode stage.
//  slave  : decode_stage side (consumes fetch and downstream status, drives stalls and AGEX latches)
//  master : environment side (fetch, later stages, testbench)
interface decode_stage_if
    import lc3b_pkg::*;
#(
    parameter int unsigned CS_W = CS_BITS
);
    logic              ld_de;
    logic [XLEN-1:0]   de_npc_in;
    logic [XLEN-1:0]   de_ir_in;
    logic              de_v_in;
    logic              ld_agex;
    logic              v_agex_ld_reg;
    logic [REG_AW-1:0] agex_drid_in;
    logic              v_agex_ld_cc;
    logic              v_mem_ld_reg;
    logic [REG_AW-1:0] mem_drid_in;
    logic              v_mem_ld_cc;
    logic              v_sr_ld_reg;
    logic [REG_AW-1:0] sr_drid;
    logic [XLEN-1:0]   sr_data;
    logic              v_sr_ld_cc;
    logic [CC_W-1:0]   sr_nzp;

    logic              dep_stall;
    logic              v_de_br_stall;
    logic [XLEN-1:0]   agex_npc;
    logic [XLEN-1:0]   agex_ir;
    logic [XLEN-1:0]   agex_sr1;
    logic [XLEN-1:0]   agex_sr2;
    logic [CC_W-1:0]   agex_cc;
    logic [REG_AW-1:0] agex_drid;
    logic [CS_W-1:0]   agex_cs;
    logic              agex_v;

    modport slave (
        input  ld_de, de_npc_in, de_ir_in, de_v_in, ld_agex,
               v_agex_ld_reg, agex_drid_in, v_agex_ld_cc,
               v_mem_ld_reg, mem_drid_in, v_mem_ld_cc,
               v_sr_ld_reg, sr_drid, sr_data, v_sr_ld_cc, sr_nzp,
        output dep_stall, v_de_br_stall,
               agex_npc, agex_ir, agex_sr1, agex_sr2, agex_cc, agex_drid, agex_cs, agex_v
    );

    modport master (
        output ld_de, de_npc_in, de_ir_in, de_v_in, ld_agex,
               v_agex_ld_reg, agex_drid_in, v_agex_ld_cc,
               v_mem_ld_reg, mem_drid_in, v_mem_ld_cc,
               v_sr_ld_reg, sr_drid, sr_data, v_sr_ld_cc, sr_nzp,
        input  dep_stall, v_de_br_stall,
               agex_npc, agex_ir, agex_sr1, agex_sr2, agex_cc, agex_drid, agex_cs, agex_v
    );

endinterface

// File: rtl/lc3b_regfile.sv
// 8x16 register file: two combinational read ports, one clocked write port, async reset to zero.
// A read that hits the address being written this cycle returns the write data.
//  clk, rst       : clock, async active-high reset
//  ra1/rd1_c      : read port 1 address / data
//  ra2/rd2_c      : read port 2 address / data
//  we, wa, wd     : write enable, address, data
module lc3b_regfile
    import lc3b_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] ra1,
    output logic [XLEN-1:0]   rd1_c,
    input  logic [REG_AW-1:0] ra2,
    output logic [XLEN-1:0]   rd2_c,
    input  logic              we,
    input  logic [REG_AW-1:0] wa,
    input  logic [XLEN-1:0]   wd
);

    logic [XLEN-1:0] regs [NREGS];

    // Storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[wa] <= wd;
        end
    end

    // Read with write-through bypass
    always_comb begin
        rd1_c = regs[ra1];
        rd2_c = regs[ra2];
        if (we && (wa == ra1)) rd1_c = wd;
        if (we && (wa == ra2)) rd2_c = wd;
    end

endmodule

// File: rtl/decode_stage.sv
// LC-3b DE pipeline stage: DE latches, register file, NZP codes, decode, RAW hazard detection,
// and the AGEX pipeline latches.
//  clk, reset : clock, async active-high reset
//  bus        : fetch inputs (ld_de, de_*_in), downstream destination status (agex/mem/sr),
//               SR write-back, stall outputs to fetch, AGEX latch outputs
module decode_stage
    import lc3b_pkg::*;
#(
    parameter logic [CC_W-1:0] RESET_CC = 3'b010,
    parameter int unsigned     CS_W     = CS_BITS
)
(
    input  logic          clk,
    input  logic          reset,
    decode_stage_if.slave bus
);

    logic [XLEN-1:0]   de_npc_q, de_ir_q;
    logic              de_v_q;
    logic [CC_W-1:0]   cc_q;

    logic [XLEN-1:0]   agex_npc_q, agex_ir_q, agex_sr1_q, agex_sr2_q;
    logic [CC_W-1:0]   agex_cc_q;
    logic [REG_AW-1:0] agex_drid_q;
    logic [CS_W-1:0]   agex_cs_q;
    logic              agex_v_q;

    logic [OP_W-1:0]   opcode;
    logic [CS_W-1:0]   cs_c;
    logic [REG_AW-1:0] drid_c, sr1_id_c, sr2_id_c;
    logic              use_sr1_c, use_sr2_c, use_cc_c;
    logic [XLEN-1:0]   sr1_val_c, sr2_val_c;
    logic [CC_W-1:0]   cc_rd_c;
    logic              dep_stall_c;

    assign opcode = de_ir_q[15:12];

    // DE latches and condition codes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            de_npc_q <= '0;
            de_ir_q  <= '0;
            de_v_q   <= 1'b0;
            cc_q     <= RESET_CC;
        end else begin
            if (bus.ld_de) begin
                de_npc_q <= bus.de_npc_in;
                de_ir_q  <= bus.de_ir_in;
                de_v_q   <= bus.de_v_in;
            end
            if (bus.v_sr_ld_cc) cc_q <= bus.sr_nzp;
        end
    end

    // Instruction decode: control word, register ids and which sources are actually consumed
    always_comb begin
        cs_c      = '0;
        use_sr1_c = 1'b0;
        use_sr2_c = 1'b0;
        use_cc_c  = 1'b0;
        unique case (opcode)
            OP_ADD, OP_AND, OP_XOR: begin
                cs_c[CS_LD_REG] = 1'b1;
                cs_c[CS_LD_CC]  = 1'b1;
                cs_c[CS_SR2MUX] = de_ir_q[5];
                use_sr1_c       = 1'b1;
                use_sr2_c       = ~de_ir_q[5];
            end
            OP_SHF: begin
                cs_c[CS_LD_REG] = 1'b1;
                cs_c[CS_LD_CC]  = 1'b1;
                use_sr1_c       = 1'b1;
            end
            OP_LDB, OP_LDW: begin
                cs_c[CS_LD_REG] = 1'b1;
                cs_c[CS_LD_CC]  = 1'b1;
                cs_c[CS_MEM_EN] = 1'b1;
                cs_c[CS_WORD]   = (opcode == OP_LDW);
                use_sr1_c       = 1'b1;
            end
            OP_LEA: begin
                cs_c[CS_LD_REG] = 1'b1;
                cs_c[CS_LD_CC]  = 1'b1;
            end
            OP_STB, OP_STW: begin
                cs_c[CS_MEM_EN] = 1'b1;
                cs_c[CS_MEM_WE] = 1'b1;
                cs_c[CS_WORD]   = (opcode == OP_STW);
                use_sr1_c       = 1'b1;
                use_sr2_c       = 1'b1;
            end
            OP_JSR: begin
                cs_c[CS_LD_REG] = 1'b1;
                cs_c[CS_BR_OP]  = 1'b1;
                cs_c[CS_JSR]    = 1'b1;
                use_sr1_c       = ~de_ir_q[11];   // JSRR takes its target from a base register
            end
            OP_TRAP: begin
                cs_c[CS_LD_REG] = 1'b1;
                cs_c[CS_BR_OP]  = 1'b1;
                cs_c[CS_JSR]    = 1'b1;
                cs_c[CS_MEM_EN] = 1'b1;
                cs_c[CS_WORD]   = 1'b1;
            end
            OP_JMP: begin
                cs_c[CS_BR_OP]  = 1'b1;
                use_sr1_c       = 1'b1;
            end
            OP_BR: begin
                cs_c[CS_BR_OP]  = 1'b1;
                use_cc_c        = |de_ir_q[11:9];  // BR never/always-false ignores NZP
            end
            default: begin
                // RTI and reserved opcodes decode as a NOP
            end
        endcase
    end

    // Register ids
    always_comb begin
        drid_c   = cs_c[CS_JSR] ? R7 : de_ir_q[11:9];
        sr1_id_c = de_ir_q[8:6];
        sr2_id_c = ((opcode == OP_STB) || (opcode == OP_STW)) ? de_ir_q[11:9] : de_ir_q[2:0];
    end

    lc3b_regfile u_regfile (
        .clk   (clk),
        .rst   (reset),
        .ra1   (sr1_id_c),
        .rd1_c (sr1_val_c),
        .ra2   (sr2_id_c),
        .rd2_c (sr2_val_c),
        .we    (bus.v_sr_ld_reg),
        .wa    (bus.sr_drid),
        .wd    (bus.sr_data)
    );

    // NZP read with same-cycle SR bypass
    always_comb begin
        cc_rd_c = bus.v_sr_ld_cc ? bus.sr_nzp : cc_q;
    end

    // RAW hazards against AGEX and MEM only; SR results arrive through the bypass
    always_comb begin
        logic hit1, hit2, cc_hit;
        hit1   = (bus.v_agex_ld_reg && (bus.agex_drid_in == sr1_id_c)) ||
                 (bus.v_mem_ld_reg  && (bus.mem_drid_in  == sr1_id_c));
        hit2   = (bus.v_agex_ld_reg && (bus.agex_drid_in == sr2_id_c)) ||
                 (bus.v_mem_ld_reg  && (bus.mem_drid_in  == sr2_id_c));
        cc_hit = bus.v_agex_ld_cc || bus.v_mem_ld_cc;
        dep_stall_c = de_v_q && ((use_sr1_c && hit1) || (use_sr2_c && hit2) || (use_cc_c && cc_hit));
    end

    // AGEX latches; a stalled DE instruction turns into a bubble
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            agex_npc_q  <= '0;
            agex_ir_q   <= '0;
            agex_sr1_q  <= '0;
            agex_sr2_q  <= '0;
            agex_cc_q   <= '0;
            agex_drid_q <= '0;
            agex_cs_q   <= '0;
            agex_v_q    <= 1'b0;
        end else if (bus.ld_agex) begin
            agex_npc_q  <= de_npc_q;
            agex_ir_q   <= de_ir_q;
            agex_sr1_q  <= sr1_val_c;
            agex_sr2_q  <= sr2_val_c;
            agex_cc_q   <= cc_rd_c;
            agex_drid_q <= drid_c;
            agex_cs_q   <= cs_c;
            agex_v_q    <= de_v_q && !dep_stall_c;
        end
    end

    assign bus.dep_stall     = dep_stall_c;
    assign bus.v_de_br_stall = de_v_q && cs_c[CS_BR_OP];
    assign bus.agex_npc      = agex_npc_q;
    assign bus.agex_ir       = agex_ir_q;
    assign bus.agex_sr1      = agex_sr1_q;
    assign bus.agex_sr2      = agex_sr2_q;
    assign bus.agex_cc       = agex_cc_q;
    assign bus.agex_drid     = agex_drid_q;
    assign bus.agex_cs       = agex_cs_q;
    assign bus.agex_v        = agex_v_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage.
module tb_decode_stage;
    import lc3b_pkg::*;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    decode_stage_if bus ();

    decode_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_de(input logic [15:0] npc, input logic [15:0] ir, input logic v);
        bus.ld_de     = 1'b1;
        bus.de_npc_in = npc;
        bus.de_ir_in  = ir;
        bus.de_v_in   = v;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus.ld_de = 0; bus.de_npc_in = '0; bus.de_ir_in = '0; bus.de_v_in = 0;
        bus.ld_agex = 0;
        bus.v_agex_ld_reg = 0; bus.agex_drid_in = '0; bus.v_agex_ld_cc = 0;
        bus.v_mem_ld_reg = 0; bus.mem_drid_in = '0; bus.v_mem_ld_cc = 0;
        bus.v_sr_ld_reg = 0; bus.sr_drid = '0; bus.sr_data = '0;
        bus.v_sr_ld_cc = 0; bus.sr_nzp = '0;
        repeat (2) step();
        check("por_agex_v", 32'(bus.agex_v), 32'h0);
        reset = 1'b0;

        // Run a little before the mid-run reset: write R3 and CC=001, push ADD R1,R2,R3
        load_de(16'h3002, 16'h1283, 1'b1);
        bus.ld_agex = 1;
        bus.v_sr_ld_reg = 1; bus.sr_drid = 3'd3; bus.sr_data = 16'h1234;
        bus.v_sr_ld_cc = 1; bus.sr_nzp = 3'b001;
        step();
        bus.v_sr_ld_reg = 0; bus.v_sr_ld_cc = 0;
        step();
        check("pre_sr2", 32'(bus.agex_sr2), 32'h1234);
        check("pre_cc", 32'(bus.agex_cc), 32'h1);

        // 1. Mid-run async reset
        reset = 1'b1;
        #1;
        check("rst_agex_v", 32'(bus.agex_v), 32'h0);
        check("rst_agex_ir", 32'(bus.agex_ir), 32'h0);
        check("rst_agex_sr2", 32'(bus.agex_sr2), 32'h0);
        step();
        reset = 1'b0;
        bus.ld_agex = 0;
        step();                                  // DE captures 0x1283
        bus.ld_de = 0; bus.ld_agex = 1;
        #1;
        check("rst_dep_stall", 32'(bus.dep_stall), 32'h0);
        step();
        check("rst_ir", 32'(bus.agex_ir), 32'h1283);
        check("rst_npc", 32'(bus.agex_npc), 32'h3002);
        check("rst_v", 32'(bus.agex_v), 32'h1);
        check("rst_r2", 32'(bus.agex_sr1), 32'h0);
        check("rst_r3", 32'(bus.agex_sr2), 32'h0);
        check("rst_cc", 32'(bus.agex_cc), 32'h2);
        check("rst_cs", 32'(bus.agex_cs), 32'h03);

        // 2. SR writes R2=5, then ADD R1,R2,#3 issues
        bus.ld_agex = 0;
        load_de(16'h3004, 16'h12A3, 1'b1);
        bus.v_sr_ld_reg = 1; bus.sr_drid = 3'd2; bus.sr_data = 16'h0005;
        step();
        bus.v_sr_ld_reg = 0; bus.ld_de = 0; bus.ld_agex = 1;
        #1;
        check("add_imm_stall", 32'(bus.dep_stall), 32'h0);
        step();
        check("add_imm_sr1", 32'(bus.agex_sr1), 32'h5);
        check("add_imm_drid", 32'(bus.agex_drid), 32'h1);
        check("add_imm_v", 32'(bus.agex_v), 32'h1);
        check("add_imm_cs", 32'(bus.agex_cs), 32'h43);
        check("add_imm_npc", 32'(bus.agex_npc), 32'h3004);

        // 3. RAW hazard on SR1 from AGEX, then on SR2 from MEM
        bus.ld_agex = 0;
        load_de(16'h3006, 16'h1283, 1'b1);
        step();
        bus.ld_de = 0;
        bus.v_agex_ld_reg = 1; bus.agex_drid_in = 3'd2;
        bus.ld_agex = 1;
        #1;
        check("haz_stall", 32'(bus.dep_stall), 32'h1);
        step();
        check("haz_bubble", 32'(bus.agex_v), 32'h0);
        check("haz_held", 32'(bus.dep_stall), 32'h1);
        bus.v_agex_ld_reg = 0;
        bus.v_mem_ld_reg = 1; bus.mem_drid_in = 3'd3;
        #1;
        check("haz_mem_sr2", 32'(bus.dep_stall), 32'h1);
        bus.mem_drid_in = 3'd1;
        #1;
        check("haz_dest_only", 32'(bus.dep_stall), 32'h0);
        bus.v_mem_ld_reg = 0;
        step();
        check("haz_issue_v", 32'(bus.agex_v), 32'h1);
        check("haz_issue_ir", 32'(bus.agex_ir), 32'h1283);
        check("haz_issue_npc", 32'(bus.agex_npc), 32'h3006);
        check("haz_issue_sr1", 32'(bus.agex_sr1), 32'h5);

        // 4. Same-cycle SR bypass of register and CC
        bus.v_sr_ld_reg = 1; bus.sr_drid = 3'd2; bus.sr_data = 16'hBEEF;
        bus.v_sr_ld_cc = 1; bus.sr_nzp = 3'b100;
        #1;
        check("byp_stall", 32'(bus.dep_stall), 32'h0);
        step();
        check("byp_sr1", 32'(bus.agex_sr1), 32'hBEEF);
        check("byp_cc", 32'(bus.agex_cc), 32'h4);
        bus.v_sr_ld_reg = 0; bus.v_sr_ld_cc = 0;

        // 5. Branches and CC hazard
        bus.ld_agex = 0;
        load_de(16'h3008, 16'h0403, 1'b1);
        step();
        bus.ld_de = 0;
        bus.v_mem_ld_cc = 1;
        #1;
        check("brz_stall", 32'(bus.dep_stall), 32'h1);
        check("brz_br_stall", 32'(bus.v_de_br_stall), 32'h1);
        load_de(16'h300A, 16'h0000, 1'b1);
        step();
        bus.ld_de = 0;
        #1;
        check("brnever_stall", 32'(bus.dep_stall), 32'h0);
        check("brnever_br_stall", 32'(bus.v_de_br_stall), 32'h1);
        bus.v_mem_ld_cc = 0;

        // 6. AGEX hold, imm ADD with unrelated IR[2:0], JSR/JSRR
        bus.ld_agex = 1;
        step();
        check("br_ir", 32'(bus.agex_ir), 32'h0);
        check("br_cs", 32'(bus.agex_cs), 32'h04);
        check("br_cc", 32'(bus.agex_cc), 32'h4);
        bus.ld_agex = 0;
        load_de(16'h300C, 16'h12BF, 1'b1);
        repeat (3) step();
        check("hold_npc", 32'(bus.agex_npc), 32'h300A);
        check("hold_v", 32'(bus.agex_v), 32'h1);
        check("hold_cs", 32'(bus.agex_cs), 32'h04);
        bus.v_agex_ld_reg = 1; bus.agex_drid_in = 3'd7;
        #1;
        check("imm_no_stall", 32'(bus.dep_stall), 32'h0);
        load_de(16'h300E, 16'h4802, 1'b1);      // simultaneous DE and AGEX load
        bus.ld_agex = 1;
        step();
        check("simul_ir", 32'(bus.agex_ir), 32'h12BF);
        check("simul_npc", 32'(bus.agex_npc), 32'h300C);
        check("simul_sr1", 32'(bus.agex_sr1), 32'hBEEF);
        check("simul_v", 32'(bus.agex_v), 32'h1);
        bus.ld_de = 0;
        #1;
        check("jsr_br_stall", 32'(bus.v_de_br_stall), 32'h1);
        check("jsr_no_stall", 32'(bus.dep_stall), 32'h0);
        step();
        check("jsr_drid", 32'(bus.agex_drid), 32'h7);
        check("jsr_cs", 32'(bus.agex_cs), 32'h85);
        check("jsr_ir", 32'(bus.agex_ir), 32'h4802);
        bus.ld_agex = 0;
        bus.agex_drid_in = 3'd2;
        load_de(16'h3010, 16'h4080, 1'b1);       // JSRR R2
        step();
        bus.ld_de = 0;
        #1;
        check("jsrr_stall", 32'(bus.dep_stall), 32'h1);
        bus.v_agex_ld_reg = 0;

        // Invalid DE slot yields a bubble and no branch stall
        load_de(16'h3012, 16'h0E07, 1'b0);
        step();
        bus.ld_de = 0; bus.ld_agex = 1;
        #1;
        check("inv_br_stall", 32'(bus.v_de_br_stall), 32'h0);
        step();
        check("inv_v", 32'(bus.agex_v), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
